// File: rtl/axicb_pkg.sv
// Shared types and limits for the AXI crossbar weighted round-robin arbiter.
package axicb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } axicb_arb_state_t;

   localparam int AXICB_MAX_REQ   = 16;
   localparam int AXICB_MAX_WGT_W = 8;

endpackage

// File: rtl/axicb_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after ptr,
// found by rotating a doubled copy of the vector and scanning from the bottom.
module axicb_rr_pick #(
   parameter int REQ_NB = 4,
   parameter int ID_W   = $clog2(REQ_NB)
) (
   input  logic [REQ_NB-1:0] elig,
   input  logic [ID_W-1:0]   ptr,
   output logic [REQ_NB-1:0] win_oh,
   output logic [ID_W-1:0]   win_id,
   output logic              win_vld
);

   logic [REQ_NB-1:0] rot;
   int                idx;

   // Scan downward so the lowest rotated position is the one that sticks.
   always_comb begin
      rot     = REQ_NB'({elig, elig} >> ptr);
      idx     = 0;
      win_oh  = '0;
      win_id  = '0;
      win_vld = 1'b0;
      for (int j = REQ_NB - 1; j >= 0; j--) begin
         if (rot[j]) begin
            idx = int'(ptr) + j;
            if (idx >= REQ_NB) begin
               idx = idx - REQ_NB;
            end
            win_vld = 1'b1;
            win_id  = ID_W'(idx);
            win_oh  = REQ_NB'(1) << idx;
         end
      end
   end

endmodule

// File: rtl/axicb_wrr_arbiter.sv
// Weighted round-robin arbiter with grant lock until done.
// Credit weighting is built only when AXICB_WRR_WEIGHTS_EN is defined.
module axicb_wrr_arbiter
   import axicb_pkg::*;
#(
   parameter int REQ_NB = 4,
   parameter int WGT_W  = 4,
   parameter int ID_W   = $clog2(REQ_NB)
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    srst,
   input  logic                    en,
   input  logic [REQ_NB-1:0]       req,
   input  logic [REQ_NB*WGT_W-1:0] weight,
   input  logic                    done,
   output logic [REQ_NB-1:0]       grant,
   output logic [ID_W-1:0]         grant_id,
   output logic                    busy
);

   if (REQ_NB < 2 || REQ_NB > AXICB_MAX_REQ) begin : g_bad_req_nb
      $error("axicb_wrr_arbiter: REQ_NB out of range");
   end
   if (WGT_W < 1 || WGT_W > AXICB_MAX_WGT_W) begin : g_bad_wgt_w
      $error("axicb_wrr_arbiter: WGT_W out of range");
   end

   axicb_arb_state_t  state_q, state_d;
   logic [REQ_NB-1:0] grant_q, grant_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   next_id;
   logic [REQ_NB-1:0] elig;
   logic [REQ_NB-1:0] pick_oh;
   logic [ID_W-1:0]   pick_id;
   logic              pick_vld;
   logic              arb_go;
   logic              release_go;
   logic              rel_adv;

   axicb_rr_pick #(
      .REQ_NB (REQ_NB),
      .ID_W   (ID_W)
   ) u_pick (
      .elig    (elig),
      .ptr     (ptr_q),
      .win_oh  (pick_oh),
      .win_id  (pick_id),
      .win_vld (pick_vld)
   );

   assign arb_go     = (state_q == IDLE) && en && (|req) && pick_vld;
   assign release_go = (state_q == LOCK) && done;
   assign next_id    = (grant_id_q == ID_W'(REQ_NB - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef AXICB_WRR_WEIGHTS_EN
   logic [WGT_W-1:0]  credit_q   [REQ_NB];
   logic [WGT_W-1:0]  credit_d   [REQ_NB];
   logic [WGT_W-1:0]  credit_eff [REQ_NB];
   logic [WGT_W-1:0]  win_credit_dec;
   logic [REQ_NB-1:0] req_with_credit;
   logic              reload;

   // Reload happens in the same cycle it is needed, so selection sees the new credits.
   always_comb begin
      req_with_credit = '0;
      elig            = '0;
      for (int i = 0; i < REQ_NB; i++) begin
         req_with_credit[i] = req[i] && (credit_q[i] != '0);
      end
      reload = (|req) && !(|req_with_credit);
      for (int i = 0; i < REQ_NB; i++) begin
         credit_eff[i] = credit_q[i];
         if (reload) begin
            credit_eff[i] = (weight[i*WGT_W +: WGT_W] == '0) ? WGT_W'(1)
                                                             : weight[i*WGT_W +: WGT_W];
         end
         elig[i] = req[i] && (credit_eff[i] != '0);
      end
   end

   always_comb begin
      credit_d       = credit_q;
      win_credit_dec = (credit_q[grant_id_q] != '0) ? credit_q[grant_id_q] - WGT_W'(1) : '0;
      rel_adv        = (win_credit_dec == '0);
      if (arb_go) begin
         credit_d = credit_eff;
      end else if (release_go) begin
         credit_d[grant_id_q] = win_credit_dec;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < REQ_NB; i++) begin
            credit_q[i] <= '0;
         end
      end else if (srst) begin
         for (int i = 0; i < REQ_NB; i++) begin
            credit_q[i] <= '0;
         end
      end else begin
         credit_q <= credit_d;
      end
   end
`else
   logic unused_weight;

   assign unused_weight = ^weight;
   assign elig          = req;
   assign rel_adv       = 1'b1;
`endif

   // Arbitrate only from IDLE; a release never arbitrates in the same cycle.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      case (state_q)
         IDLE: begin
            if (arb_go) begin
               state_d    = LOCK;
               grant_d    = pick_oh;
               grant_id_d = pick_id;
            end
         end
         LOCK: begin
            if (release_go) begin
               state_d    = IDLE;
               grant_d    = '0;
               grant_id_d = '0;
               ptr_d      = rel_adv ? next_id : grant_id_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
      end else if (srst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q == LOCK);

endmodule

// File: tb/tb_axicb_wrr_arbiter.sv
// Self-checking bench for axicb_wrr_arbiter (REQ_NB=4 and REQ_NB=5 instances).
// Follows AXICB_WRR_WEIGHTS_EN the same way the RTL does.
module tb_axicb_wrr_arbiter;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int N5 = 5;
`ifdef AXICB_WRR_WEIGHTS_EN
   localparam bit WEIGHTED = 1'b1;
`else
   localparam bit WEIGHTED = 1'b0;
`endif

   logic           aclk = 1'b0;
   logic           areset, srst, en, done;
   logic [N-1:0]   req;
   logic [N*W-1:0] weight;
   logic [N-1:0]   grant;
   logic [1:0]     grant_id;
   logic           busy;

   logic            en5, done5;
   logic [N5-1:0]   req5;
   logic [N5*W-1:0] weight5;
   logic [N5-1:0]   grant5;
   logic [2:0]      grant_id5;
   logic            busy5;

   int checks   = 0;
   int failures = 0;

   int m_busy, m_win, m_ptr;
   int m_credit [N];

   typedef struct {
      bit         en;
      logic [3:0] req;
      bit         done;
      int         exp_grant;
      int         exp_id;
      int         exp_busy;
   } vec_t;

   vec_t tbl [12];
   int   ord [9];

   axicb_wrr_arbiter #(.REQ_NB(N), .WGT_W(W)) dut (
      .aclk(aclk), .areset(areset), .srst(srst), .en(en), .req(req), .weight(weight),
      .done(done), .grant(grant), .grant_id(grant_id), .busy(busy)
   );

   axicb_wrr_arbiter #(.REQ_NB(N5), .WGT_W(W)) dut5 (
      .aclk(aclk), .areset(areset), .srst(1'b0), .en(en5), .req(req5), .weight(weight5),
      .done(done5), .grant(grant5), .grant_id(grant_id5), .busy(busy5)
   );

   always #5 aclk = ~aclk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      m_busy = 0;
      m_win  = 0;
      m_ptr  = 0;
      for (int i = 0; i < N; i++) m_credit[i] = 0;
   endtask

   function automatic int weightOf(input int i);
      int w;
      w = int'((weight >> (i * W)) & 16'hF);
      return (w == 0) ? 1 : w;
   endfunction

   // Reference behaviour: one clock edge of the arbiter, from the rules directly.
   task automatic modelEdge(input bit en_i, input logic [N-1:0] req_i, input bit done_i,
                            input bit srst_i);
      bit any;
      int i;
      if (srst_i) begin
         modelReset();
      end else if (m_busy != 0) begin
         if (done_i) begin
            if (WEIGHTED) begin
               if (m_credit[m_win] > 0) m_credit[m_win]--;
               m_ptr = (m_credit[m_win] == 0) ? (m_win + 1) % N : m_win;
            end else begin
               m_ptr = (m_win + 1) % N;
            end
            m_busy = 0;
         end
      end else if (en_i && req_i != '0) begin
         if (WEIGHTED) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) if (req_i[k] && m_credit[k] > 0) any = 1'b1;
            if (!any) for (int k = 0; k < N; k++) m_credit[k] = weightOf(k);
         end
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_i[i] && (!WEIGHTED || m_credit[i] > 0)) begin
               m_win  = i;
               m_busy = 1;
               break;
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit en_i, input logic [N-1:0] req_i, input bit done_i,
                                input bit srst_i);
      en   = en_i;
      req  = req_i;
      done = done_i;
      srst = srst_i;
      @(posedge aclk);
      modelEdge(en_i, req_i, done_i, srst_i);
      #1;
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "_busy"}, int'(busy), m_busy);
      checkOutput({tag, "_grant"}, int'(grant), (m_busy != 0) ? (1 << m_win) : 0);
      checkOutput({tag, "_id"}, int'(grant_id), (m_busy != 0) ? m_win : 0);
   endtask

   task automatic doReset();
      areset = 1'b1;
      srst   = 1'b0;
      en     = 1'b0;
      req    = '0;
      done   = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      modelReset();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the test finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      en5     = 1'b0;
      done5   = 1'b0;
      req5    = '0;
      weight5 = 20'h11111;
      weight  = 16'h1111;

      tbl[0]  = '{0, 4'hF, 0, 0, 0, 0};
      tbl[1]  = '{0, 4'hF, 1, 0, 0, 0};
      tbl[2]  = '{1, 4'hF, 0, 1, 0, 1};
      tbl[3]  = '{1, 4'hF, 1, 0, 0, 0};
      tbl[4]  = '{1, 4'hF, 0, 2, 1, 1};
      tbl[5]  = '{1, 4'hF, 1, 0, 0, 0};
      tbl[6]  = '{1, 4'hF, 0, 4, 2, 1};
      tbl[7]  = '{1, 4'hF, 1, 0, 0, 0};
      tbl[8]  = '{1, 4'hF, 0, 8, 3, 1};
      tbl[9]  = '{1, 4'hF, 1, 0, 0, 0};
      tbl[10] = '{1, 4'hF, 0, 1, 0, 1};
      tbl[11] = '{0, 4'h0, 1, 0, 0, 0};

      doReset();
      checkOutput("reset_grant", int'(grant), 0);
      checkOutput("reset_id", int'(grant_id), 0);
      checkOutput("reset_busy", int'(busy), 0);

      for (int v = 0; v < 12; v++) begin
         applyStimulus(tbl[v].en, tbl[v].req, tbl[v].done, 1'b0);
         checkOutput($sformatf("tbl%0d_grant", v), int'(grant), tbl[v].exp_grant);
         checkOutput($sformatf("tbl%0d_id", v), int'(grant_id), tbl[v].exp_id);
         checkOutput($sformatf("tbl%0d_busy", v), int'(busy), tbl[v].exp_busy);
      end

      // Non-power-of-2 wrap on the five-requester instance.
      doReset();
      en5 = 1'b1; req5 = 5'b10000; done5 = 1'b0;
      @(posedge aclk); #1;
      checkOutput("n5_first_id", int'(grant_id5), 4);
      checkOutput("n5_first_grant", int'(grant5), 16);
      done5 = 1'b1;
      @(posedge aclk); #1;
      checkOutput("n5_first_rel", int'(busy5), 0);
      done5 = 1'b0; req5 = 5'b00001;
      @(posedge aclk); #1;
      checkOutput("n5_wrap_id", int'(grant_id5), 0);
      done5 = 1'b1;
      @(posedge aclk); #1;
      done5 = 1'b0; req5 = 5'b10001;
      @(posedge aclk); #1;
      checkOutput("n5_scan_id", int'(grant_id5), 4);
      done5 = 1'b1;
      @(posedge aclk); #1;
      done5 = 1'b0;
      @(posedge aclk); #1;
      checkOutput("n5_wrap2_id", int'(grant_id5), 0);
      en5 = 1'b0; req5 = '0; done5 = 1'b1;
      @(posedge aclk); #1;
      done5 = 1'b0;

      // Grant order with weights {3,1,1,1} (or plain round-robin with weights tied to 0).
      if (WEIGHTED) begin
         weight = 16'h1113;
         ord = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
      end else begin
         weight = 16'h0000;
         ord = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
      end
      doReset();
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
         checkOutput($sformatf("order%0d_id", k), int'(grant_id), ord[k]);
         checkOutput($sformatf("order%0d_busy", k), int'(busy), 1);
         applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
         checkOutput($sformatf("order%0d_rel", k), int'(busy), 0);
      end

      // Grant is held regardless of req changes until done.
      weight = 16'h1111;
      doReset();
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
      checkOutput("hold_start_grant", int'(grant), 2);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
         checkOutput($sformatf("hold%0d_grant", k), int'(grant), 2);
         checkOutput($sformatf("hold%0d_busy", k), int'(busy), 1);
      end
      applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0);
      checkOutput("hold_rel_busy", int'(busy), 0);
      checkOutput("hold_rel_grant", int'(grant), 0);
      applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
      checkOutput("hold_next_grant", int'(grant), 8);

      // Asynchronous reset mid-grant, then srst racing done.
      #2;
      areset = 1'b1;
      #1;
      checkOutput("areset_grant", int'(grant), 0);
      checkOutput("areset_busy", int'(busy), 0);
      checkOutput("areset_id", int'(grant_id), 0);
      modelReset();
      @(posedge aclk); #1;
      areset = 1'b0;
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
      checkOutput("post_areset_grant", int'(grant), 1);
      applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
      checkOutput("pre_srst_grant", int'(grant), 2);
      applyStimulus(1'b1, 4'hF, 1'b1, 1'b1);
      checkOutput("srst_busy", int'(busy), 0);
      checkOutput("srst_grant", int'(grant), 0);
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
      checkOutput("post_srst_grant", int'(grant), 1);

      // Randomised run against the reference model.
      doReset();
      for (int c = 0; c < 400; c++) begin
         if (c % 64 == 0) weight = 16'($urandom);
         applyStimulus(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) == 0,
                       ($urandom % 50) == 0);
         checkModel($sformatf("rnd%0d", c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
